muldiv_unit: RTL and testbench

- Parametrised iterative integer multiply/divide unit implementing the RV32M operation set (MUL, MULH, MULHSU, MULHU, DIV, DIVU, REM, REMU) at width XLEN.
- Sits beside the combinational ALU in the execute stage.
- The core issues an operation through a valid/ready handshake, stalls while the unit is busy, and takes the result through a second valid/ready handshake.
- A flush input abandons an in-flight operation on a pipeline redirect.

---
 rtl/muldiv_unit.sv | 139 +++++++++++++
 tb/tb_muldiv_unit.sv | 204 ++++++++++++++++++++
 2 files changed

// File: rtl/muldiv_unit.sv
// Iterative RV32M multiply/divide unit: one radix-2 step per cycle,
// with sign fix-up in a final stage and a fast path for divide-by-zero/overflow.
module muldiv_unit #(
  parameter int XLEN = 32
) (
  input  logic            clk,
  input  logic            rstN,
  input  logic            inValid,
  output logic            inReady,
  input  logic [2:0]      funct3,
  input  logic [XLEN-1:0] srcA,
  input  logic [XLEN-1:0] srcB,
  input  logic            flush,
  output logic            outValid,
  input  logic            outReady,
  output logic [XLEN-1:0] result
);

  localparam int CW = $clog2(XLEN) + 1;

  typedef enum logic [1:0] {IDLE, CALC, SIGN, DONE} state_t;

  state_t          state, state_next;
  logic [2:0]      op;
  logic [XLEN-1:0] hi, lo, b_mag;
  logic [CW-1:0]   cnt;
  logic            neg_res, neg_rem;

  // Request decode, only meaningful at the acceptance edge.
  logic            is_div, a_signed, b_signed, a_neg, b_neg;
  logic            div_zero, div_ovf, fast, accept;
  logic [XLEN-1:0] a_abs, b_abs, fast_result;

  always_comb begin
    is_div   = funct3[2];
    a_signed = is_div ? ~funct3[0] : (funct3 == 3'b001 || funct3 == 3'b010);
    b_signed = is_div ? ~funct3[0] : (funct3 == 3'b001);
    a_neg    = a_signed & srcA[XLEN-1];
    b_neg    = b_signed & srcB[XLEN-1];
    a_abs    = a_neg ? -srcA : srcA;
    b_abs    = b_neg ? -srcB : srcB;
    div_zero = is_div && (srcB == '0);
    div_ovf  = is_div && !funct3[0] && (srcA == {1'b1, {(XLEN-1){1'b0}}}) && (srcB == '1);
    fast     = div_zero || div_ovf;
    if (div_zero) fast_result = funct3[1] ? srcA : '1;
    else          fast_result = funct3[1] ? '0 : srcA;
    accept   = inValid && inReady && !flush;
  end

  // One radix-2 step: multiply shifts {hi,lo} right with add; divide shifts left with restore.
  logic [XLEN:0]   mul_sum, div_trial, div_diff;
  logic [XLEN-1:0] hi_next, lo_next;

  always_comb begin
    mul_sum   = {1'b0, hi} + (lo[0] ? {1'b0, b_mag} : '0);
    div_trial = {hi, lo[XLEN-1]};
    div_diff  = div_trial - {1'b0, b_mag};
    if (!op[2]) begin
      hi_next = mul_sum[XLEN:1];
      lo_next = {mul_sum[0], lo[XLEN-1:1]};
    end else if (!div_diff[XLEN]) begin
      hi_next = div_diff[XLEN-1:0];
      lo_next = {lo[XLEN-2:0], 1'b1};
    end else begin
      hi_next = div_trial[XLEN-1:0];
      lo_next = {lo[XLEN-2:0], 1'b0};
    end
  end

  logic [2*XLEN-1:0] prod_signed;
  logic [XLEN-1:0]   sign_result;

  always_comb begin
    prod_signed = neg_res ? -{hi, lo} : {hi, lo};
    case (op)
      3'b000:                 sign_result = prod_signed[XLEN-1:0];
      3'b001, 3'b010, 3'b011: sign_result = prod_signed[2*XLEN-1:XLEN];
      3'b100, 3'b101:         sign_result = neg_res ? -lo : lo;
      default:                sign_result = neg_rem ? -hi : hi;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples pre-edge values regardless of process ordering.
  always_ff @(posedge clk or negedge rstN) begin
    if (!rstN) state <= IDLE;
    else       state <= state_next;
  end

  // NOTE: every always_comb output gets a default first so no latch is inferred.
  always_comb begin
    state_next = state;
    if (flush) begin
      state_next = IDLE;
    end else begin
      case (state)
        IDLE: if (inValid) state_next = fast ? DONE : CALC;
        CALC: if (cnt == CW'(1)) state_next = SIGN;
        SIGN: state_next = DONE;
        DONE: if (outReady) state_next = IDLE;
        default: state_next = IDLE;
      endcase
    end
  end

  always_comb begin
    inReady  = (state == IDLE);
    outValid = (state == DONE);
  end

  always_ff @(posedge clk or negedge rstN) begin
    if (!rstN) begin
      op      <= '0;
      hi      <= '0;
      lo      <= '0;
      b_mag   <= '0;
      cnt     <= '0;
      neg_res <= 1'b0;
      neg_rem <= 1'b0;
      result  <= '0;
    end else if (accept) begin
      op      <= funct3;
      hi      <= '0;
      lo      <= is_div ? a_abs : b_abs;
      b_mag   <= is_div ? b_abs : a_abs;
      cnt     <= CW'(XLEN);
      neg_res <= a_neg ^ b_neg;
      neg_rem <= a_neg;
      if (fast) result <= fast_result;
    end else if (!flush && state == CALC) begin
      hi  <= hi_next;
      lo  <= lo_next;
      cnt <= cnt - CW'(1);
    end else if (!flush && state == SIGN) begin
      result <= sign_result;
    end
  end

endmodule

// File: tb/tb_muldiv_unit.sv
// Directed bench for muldiv_unit: stimulus pushes expected results into a
// scoreboard queue, a negedge monitor pops and compares on each handoff.
module tb_muldiv_unit;

  localparam int XLEN = 32;

  logic            clk = 1'b0;
  logic            rstN = 1'b0;
  logic            inValid = 1'b0;
  logic            inReady;
  logic [2:0]      funct3 = '0;
  logic [XLEN-1:0] srcA = '0;
  logic [XLEN-1:0] srcB = '0;
  logic            flush = 1'b0;
  logic            outValid;
  logic            outReady = 1'b1;
  logic [XLEN-1:0] result;

  int n_vec  = 0;
  int n_fail = 0;

  logic [XLEN-1:0] exp_q[$];
  string           name_q[$];

  muldiv_unit #(.XLEN(XLEN)) dut (
    .clk(clk), .rstN(rstN), .inValid(inValid), .inReady(inReady),
    .funct3(funct3), .srcA(srcA), .srcB(srcB), .flush(flush),
    .outValid(outValid), .outReady(outReady), .result(result)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [XLEN-1:0] act, input logic [XLEN-1:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  // Scoreboard monitor: a handoff happens at the next posedge when valid && ready.
  always @(negedge clk) begin
    if (rstN && outValid && outReady && !flush) begin
      if (exp_q.size() == 0) begin
        check("unexpected result", result, 'x);
      end else begin
        check(name_q.pop_front(), result, exp_q.pop_front());
      end
    end
  end

  task automatic wait_ready();
    int n = 0;
    while (!inReady && n < 200) begin
      @(posedge clk); #1;
      n++;
    end
    if (n >= 200) check("inReady timeout", 32'(n), 32'(0));
  endtask

  // Issue one request; returns at the negedge where outValid is first seen.
  task automatic issue(input logic [2:0] f3, input logic [XLEN-1:0] a, input logic [XLEN-1:0] b,
                       input logic [XLEN-1:0] exp, input int exp_lat, input string name);
    int   lat;
    logic ready_low;
    @(posedge clk); #1;
    wait_ready();
    inValid = 1'b1; funct3 = f3; srcA = a; srcB = b;
    exp_q.push_back(exp);
    name_q.push_back(name);
    @(posedge clk); #1;
    inValid = 1'b0;
    funct3 = 3'($urandom); srcA = $urandom; srcB = $urandom;
    lat = 1;
    ready_low = 1'b1;
    @(negedge clk);
    while (!outValid && lat < 100) begin
      if (inReady) ready_low = 1'b0;
      @(negedge clk);
      lat++;
    end
    check({name, " latency"}, 32'(lat), 32'(exp_lat));
    check({name, " inReady low while busy"}, 32'(ready_low), 32'(1));
  endtask

  // Start an operation without expecting a result (it will be abandoned).
  task automatic start_only(input logic [2:0] f3, input logic [XLEN-1:0] a, input logic [XLEN-1:0] b);
    @(posedge clk); #1;
    wait_ready();
    inValid = 1'b1; funct3 = f3; srcA = a; srcB = b;
    @(posedge clk); #1;
    inValid = 1'b0;
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int   n;
    logic seen;

    #2;
    check("reset inReady", 32'(inReady), 32'(1));
    check("reset outValid", 32'(outValid), 32'(0));
    check("reset result", result, 32'h0);
    #20 rstN = 1'b1;

    // Multiply family
    issue(3'b000, 32'd7,        32'hFFFF_FFFD, 32'hFFFF_FFEB, 34, "MUL 7*-3");
    issue(3'b000, 32'h1234_5678, 32'h10,       32'h2345_6780, 34, "MUL shift");
    issue(3'b001, 32'h8000_0000, 32'h8000_0000, 32'h4000_0000, 34, "MULH min*min");
    issue(3'b011, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE, 34, "MULHU max*max");
    issue(3'b010, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 34, "MULHSU -1*max");
    issue(3'b011, 32'h8000_0000, 32'h4,         32'h2,         34, "MULHU 2^31*4");

    // Divide family
    issue(3'b100, 32'hFFFF_FFF9, 32'd2,         32'hFFFF_FFFD, 34, "DIV -7/2");
    issue(3'b110, 32'hFFFF_FFF9, 32'd2,         32'hFFFF_FFFF, 34, "REM -7,2");
    issue(3'b101, 32'hFFFF_FFF9, 32'd2,         32'h7FFF_FFFC, 34, "DIVU big/2");
    issue(3'b111, 32'hFFFF_FFF9, 32'd2,         32'h1,         34, "REMU big,2");
    issue(3'b100, 32'd100,       32'hFFFF_FFF9, 32'hFFFF_FFF2, 34, "DIV 100/-7");
    issue(3'b110, 32'd100,       32'hFFFF_FFF9, 32'h2,         34, "REM 100,-7");

    // Fast path
    issue(3'b101, 32'd7,         32'd0,         32'hFFFF_FFFF, 1, "DIVU by zero");
    issue(3'b110, 32'd7,         32'd0,         32'd7,         1, "REM by zero");
    issue(3'b100, 32'h8000_0000, 32'hFFFF_FFFF, 32'h8000_0000, 1, "DIV overflow");
    issue(3'b110, 32'h8000_0000, 32'hFFFF_FFFF, 32'h0,         1, "REM overflow");

    // Backpressure: hold the result, then hand off with a request already waiting.
    @(posedge clk); #1;
    outReady = 1'b0;
    issue(3'b101, 32'd100, 32'd7, 32'd14, 34, "DIVU backpressure");
    for (int i = 0; i < 5; i++) begin
      check("stall outValid", 32'(outValid), 32'(1));
      check("stall result", result, 32'd14);
      check("stall inReady", 32'(inReady), 32'(0));
      @(negedge clk);
    end
    @(posedge clk); #1;
    outReady = 1'b1;
    inValid = 1'b1; funct3 = 3'b110; srcA = 32'hFFFF_FF9C; srcB = 32'd7;
    exp_q.push_back(32'hFFFF_FFFE);
    name_q.push_back("REM -100,7 back-to-back");
    @(posedge clk); #1;
    outReady = 1'b0;
    @(negedge clk);
    check("after handoff inReady", 32'(inReady), 32'(1));
    check("after handoff outValid", 32'(outValid), 32'(0));
    @(posedge clk); #1;
    inValid = 1'b0;
    check("back-to-back accepted", 32'(inReady), 32'(0));
    outReady = 1'b1;
    n = 0;
    while (!outValid && n < 100) begin
      @(negedge clk);
      n++;
    end
    check("back-to-back completes", 32'(outValid), 32'(1));

    // Flush on the tenth CALC cycle.
    start_only(3'b000, 32'd12345, 32'd678);
    repeat (9) @(posedge clk);
    #1 flush = 1'b1;
    @(posedge clk); #1;
    flush = 1'b0;
    @(negedge clk);
    check("flush inReady", 32'(inReady), 32'(1));
    check("flush outValid", 32'(outValid), 32'(0));
    seen = 1'b0;
    repeat (40) begin
      @(negedge clk);
      if (outValid) seen = 1'b1;
    end
    check("flushed op never valid", 32'(seen), 32'(0));
    issue(3'b000, 32'd3, 32'd5, 32'd15, 34, "MUL after flush");

    // Asynchronous reset in the middle of CALC.
    start_only(3'b100, 32'd1000, 32'd3);
    repeat (5) @(posedge clk);
    #2 rstN = 1'b0;
    #1;
    check("mid reset inReady", 32'(inReady), 32'(1));
    check("mid reset outValid", 32'(outValid), 32'(0));
    check("mid reset result", result, 32'h0);
    @(negedge clk);
    rstN = 1'b1;
    issue(3'b100, 32'hFFFF_FF9C, 32'd7, 32'hFFFF_FFF2, 34, "DIV after reset");

    n = 0;
    while (exp_q.size() != 0 && n < 100) begin
      @(negedge clk);
      n++;
    end
    check("scoreboard drained", 32'(exp_q.size()), 32'(0));

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
    $finish;
  end

endmodule
